// File: rtl/xaui_tx_idle_ctrl_pkg.sv
// Shared XAUI tx idle definitions: state codes, IFG flags, spacing default, LFSR taps.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package xaui_tx_idle_ctrl_pkg;

    // Idle-sequence states, common to this sequencer and the tx idle datapath
    typedef enum logic [2:0] {
        SEND_A        = 3'd1,
        SEND_K        = 3'd2,
        SEND_Q        = 3'd3,
        SEND_RANDOM_R = 3'd4,
        SEND_RANDOM_K = 3'd5,
        SEND_RANDOM_A = 3'd6,
        SEND_RANDOM_Q = 3'd7
    } tx_state_e;

    localparam logic IFG_A = 1'b0;
    localparam logic IFG_K = 1'b1;

    localparam int         A_MIN_SPACING_DEF = 16;
    localparam logic [6:0] LFSR_SEED_DEF     = 7'h7F;

    // x^7 + x^6 + 1: feedback is bit 6 xor bit 5
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones
    function automatic logic [6:0] lfsr_seed_fix(input logic [6:0] seed);
        return (seed == 7'd0) ? 7'h7F : seed;
    endfunction

    // States in which a ||Q|| is already on its way out
    function automatic logic is_q_state(input logic [2:0] s);
        return (s == SEND_Q) || (s == SEND_RANDOM_Q);
    endfunction

endpackage

// File: rtl/xaui_tx_idle_ctrl_lfsr.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1) supplying the pseudo-random R/K code select.
// Latency: one clk per advance; reset loads the (zero-corrected) seed.
// Backpressure: none; advances whenever i_adv is high.
module xaui_tx_lfsr
    import xaui_tx_idle_ctrl_pkg::*;
#(
    parameter logic [6:0] SEED = LFSR_SEED_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_adv,
    output logic [3:0] o_nibble,
    output logic       o_code_sel
);

    localparam logic [6:0] SEED_EFF = lfsr_seed_fix(SEED);

    logic [6:0] r_lfsr;

    // Shift left, feeding back the tap xor into bit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED_EFF;
        end else if (i_adv) begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO]};
        end
    end

    assign o_nibble   = r_lfsr[3:0];
    assign o_code_sel = r_lfsr[0];

endmodule

// File: rtl/xaui_tx_idle_ctrl.sv
// XAUI tx idle sequencer: state loop, ||A|| spacing, code select, ||Q|| scheduling (XAUI_TX_STATS_EN adds counters).
// Latency: one clk from next_* / link_status_in to every registered output.
// Backpressure: status events wait while a ||Q|| is pending or being sent; changes are deferred, never dropped.
module xaui_tx_idle_ctrl
    import xaui_tx_idle_ctrl_pkg::*;
#(
    parameter int         A_MIN_SPACING    = A_MIN_SPACING_DEF,
    parameter logic [6:0] LFSR_SEED        = LFSR_SEED_DEF,
    parameter int         Q_REFRESH_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  next_state,
    input  logic        next_ifg,
    input  logic        next_q_det,
    input  logic        a_send,
    input  logic [31:0] link_status_in,
    output logic [2:0]  current_state,
    output logic        current_ifg,
    output logic        current_q_det,
    output logic [4:0]  a_cnt,
    output logic        code_sel,
    output logic [31:0] link_status,
    output logic        link_status_event
`ifdef XAUI_TX_STATS_EN
    ,
    output logic [15:0] a_count,
    output logic [15:0] q_count
`endif
);

    localparam logic [4:0]  A_BASE       = 5'(A_MIN_SPACING);
    localparam bit          REFRESH_EN   = (Q_REFRESH_CYCLES != 0);
    localparam logic [15:0] REFRESH_LAST = 16'(Q_REFRESH_CYCLES - 1);

    logic [2:0]  r_state;
    logic        r_ifg;
    logic        r_q_det;
    logic [4:0]  r_a_cnt;
    logic [31:0] r_link_status;
    logic        r_event;
    logic [15:0] r_refresh;

    logic [3:0]  w_lfsr_nib;
    logic        w_code_sel;
    logic        w_refresh_exp;
    logic        w_trigger;
    logic        w_blocked;
    logic        w_fire;

    xaui_tx_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .i_adv      (1'b1),
        .o_nibble   (w_lfsr_nib),
        .o_code_sel (w_code_sel)
    );

    // Close the datapath's next_* feedback loop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEND_RANDOM_R;
            r_ifg   <= IFG_A;
            r_q_det <= 1'b0;
        end else begin
            r_state <= next_state;
            r_ifg   <= next_ifg;
            r_q_det <= next_q_det;
        end
    end

    // ||A|| spacing: reload on send (pre-advance LFSR), else count down to 0 and hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_cnt <= A_BASE;
        end else if (a_send) begin
            r_a_cnt <= A_BASE + {1'b0, w_lfsr_nib};
        end else if (r_a_cnt != 5'd0) begin
            r_a_cnt <= r_a_cnt - 5'd1;
        end
    end

    // Expiry stays asserted (counter parked) until an event actually goes out
    assign w_refresh_exp = REFRESH_EN && (r_refresh == REFRESH_LAST);
    assign w_trigger     = (link_status_in != r_link_status) || w_refresh_exp;
    assign w_blocked     = r_q_det || is_q_state(r_state);
    assign w_fire        = w_trigger && !w_blocked;

    // Issue a one-cycle ||Q|| request and capture the status it carries
    always_ff @(posedge clk) begin
        if (reset) begin
            r_link_status <= 32'h0;
            r_event       <= 1'b0;
        end else begin
            r_event <= w_fire;
            if (w_fire) begin
                r_link_status <= link_status_in;
            end
        end
    end

    // Periodic resend timer: restarts on every event, parks at expiry while blocked
    always_ff @(posedge clk) begin
        if (reset || !REFRESH_EN || w_fire) begin
            r_refresh <= 16'd0;
        end else if (!w_refresh_exp) begin
            r_refresh <= r_refresh + 16'd1;
        end
    end

`ifdef XAUI_TX_STATS_EN
    logic [15:0] r_a_count;
    logic [15:0] r_q_count;

    // Saturating counts of ||A|| columns sent and cycles spent sending ||Q||
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_count <= 16'd0;
            r_q_count <= 16'd0;
        end else begin
            if (a_send && (r_a_count != 16'hFFFF)) begin
                r_a_count <= r_a_count + 16'd1;
            end
            if (is_q_state(r_state) && (r_q_count != 16'hFFFF)) begin
                r_q_count <= r_q_count + 16'd1;
            end
        end
    end

    assign a_count = r_a_count;
    assign q_count = r_q_count;
`endif

    assign current_state     = r_state;
    assign current_ifg       = r_ifg;
    assign current_q_det     = r_q_det;
    assign a_cnt             = r_a_cnt;
    assign code_sel          = w_code_sel;
    assign link_status       = r_link_status;
    assign link_status_event = r_event;

endmodule

// File: tb/tb_xaui_tx_idle_ctrl.sv
// Bench for xaui_tx_idle_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Two instances share stimulus: refresh period 8 (dut) and refresh disabled (dut0).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_xaui_tx_idle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  next_state;
    logic        next_ifg;
    logic        next_q_det;
    logic        a_send;
    logic [31:0] link_status_in;

    logic [2:0]  current_state, current_state0;
    logic        current_ifg, current_ifg0;
    logic        current_q_det, current_q_det0;
    logic [4:0]  a_cnt, a_cnt0;
    logic        code_sel, code_sel0;
    logic [31:0] link_status, link_status0;
    logic        link_status_event, link_status_event0;
`ifdef XAUI_TX_STATS_EN
    logic [15:0] a_count, q_count, a_count0, q_count0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    xaui_tx_idle_ctrl #(.Q_REFRESH_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .next_state(next_state), .next_ifg(next_ifg),
        .next_q_det(next_q_det), .a_send(a_send), .link_status_in(link_status_in),
        .current_state(current_state), .current_ifg(current_ifg), .current_q_det(current_q_det),
        .a_cnt(a_cnt), .code_sel(code_sel), .link_status(link_status),
        .link_status_event(link_status_event)
`ifdef XAUI_TX_STATS_EN
        , .a_count(a_count), .q_count(q_count)
`endif
    );

    xaui_tx_idle_ctrl #(.Q_REFRESH_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .next_state(next_state), .next_ifg(next_ifg),
        .next_q_det(next_q_det), .a_send(a_send), .link_status_in(link_status_in),
        .current_state(current_state0), .current_ifg(current_ifg0), .current_q_det(current_q_det0),
        .a_cnt(a_cnt0), .code_sel(code_sel0), .link_status(link_status0),
        .link_status_event(link_status_event0)
`ifdef XAUI_TX_STATS_EN
        , .a_count(a_count0), .q_count(q_count0)
`endif
    );

    // ---------------- behavioural model ----------------
    int          PER [2] = '{8, 0};
    logic [2:0]  m_state = 3'd0;
    logic        m_ifg = 1'b0, m_qdet = 1'b0;
    logic [6:0]  m_lfsr = 7'h7F;
    int          m_acnt = 0;
    logic [31:0] m_ls [2] = '{32'h0, 32'h0};
    logic        m_evt [2] = '{1'b0, 1'b0};
    int          m_rc [2] = '{0, 0};
    int          m_acount = 0, m_qcount = 0;

    task automatic tick();
        logic [2:0]  n_state;
        logic        n_ifg, n_qdet;
        logic [6:0]  n_lfsr;
        int          n_acnt, n_ac, n_qc;
        logic [31:0] n_ls [2];
        logic        n_evt [2];
        int          n_rc [2];
        bit          blocked, trig;
        if (reset) begin
            n_state = 3'd4; n_ifg = 1'b0; n_qdet = 1'b0;
            n_lfsr = 7'h7F; n_acnt = 16; n_ac = 0; n_qc = 0;
            for (int k = 0; k < 2; k++) begin
                n_ls[k] = 32'h0; n_evt[k] = 1'b0; n_rc[k] = 0;
            end
        end else begin
            n_state = next_state; n_ifg = next_ifg; n_qdet = next_q_det;
            n_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
            if (a_send)          n_acnt = 16 + int'(m_lfsr[3:0]);
            else if (m_acnt > 0) n_acnt = m_acnt - 1;
            else                 n_acnt = 0;
            blocked = m_qdet || (m_state == 3'd3) || (m_state == 3'd7);
            for (int k = 0; k < 2; k++) begin
                trig = (link_status_in != m_ls[k]) || (PER[k] != 0 && m_rc[k] == PER[k] - 1);
                n_evt[k] = trig && !blocked;
                n_ls[k]  = n_evt[k] ? link_status_in : m_ls[k];
                if (PER[k] == 0 || n_evt[k])     n_rc[k] = 0;
                else if (m_rc[k] == PER[k] - 1)  n_rc[k] = m_rc[k];
                else                             n_rc[k] = m_rc[k] + 1;
            end
            n_ac = (a_send && m_acount < 65535) ? m_acount + 1 : m_acount;
            n_qc = ((m_state == 3'd3 || m_state == 3'd7) && m_qcount < 65535) ? m_qcount + 1 : m_qcount;
        end
        @(posedge clk);
        #1;
        m_state = n_state; m_ifg = n_ifg; m_qdet = n_qdet; m_lfsr = n_lfsr;
        m_acnt = n_acnt; m_acount = n_ac; m_qcount = n_qc;
        for (int k = 0; k < 2; k++) begin
            m_ls[k] = n_ls[k]; m_evt[k] = n_evt[k]; m_rc[k] = n_rc[k];
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; next_state = 3'd4; next_ifg = 1'b0; next_q_det = 1'b0;
        a_send = 1'b0; link_status_in = 32'h0;
        repeat (3) tick();
        n_checks++; if (current_state !== 3'd4) $display("FAIL reset_state got %0d want 4", current_state); else n_pass++;
        n_checks++; if (current_ifg !== 1'b0) $display("FAIL reset_ifg got %b want 0", current_ifg); else n_pass++;
        n_checks++; if (current_q_det !== 1'b0) $display("FAIL reset_qdet got %b want 0", current_q_det); else n_pass++;
        n_checks++; if (a_cnt !== 5'd16) $display("FAIL reset_acnt got %0d want 16", a_cnt); else n_pass++;
        n_checks++; if (code_sel !== 1'b1) $display("FAIL reset_codesel got %b want 1", code_sel); else n_pass++;
        n_checks++; if (link_status !== 32'h0 || link_status_event !== 1'b0)
            $display("FAIL reset_status got %h/%b want 0/0", link_status, link_status_event); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (a_cnt !== 5'((i < 15) ? 15 - i : 0))
                $display("FAIL acnt_countdown cycle %0d got %0d want %0d", i, a_cnt, (i < 15) ? 15 - i : 0);
            else n_pass++;
        end
    endtask

    task automatic test_lfsr();
        logic [6:0] start;
        int errs;
        start = m_lfsr;
        errs = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (code_sel !== m_lfsr[0] || dut.u_lfsr.r_lfsr !== m_lfsr) errs++;
            if (dut.u_lfsr.r_lfsr == 7'd0) errs++;
            if (i < 126 && dut.u_lfsr.r_lfsr == start) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL lfsr_sequence got %0d bad cycles want 0", errs); else n_pass++;
        n_checks++; if (dut.u_lfsr.r_lfsr !== start)
            $display("FAIL lfsr_period got %h want %h after 127 cycles", dut.u_lfsr.r_lfsr, start); else n_pass++;
    endtask

    task automatic test_a_send();
        int guard;
        int expv;
        guard = 0;
        while (m_lfsr[3:0] != 4'hA && guard < 200) begin tick(); guard++; end
        a_send = 1'b1; tick(); a_send = 1'b0;
        n_checks++; if (a_cnt !== 5'd26) $display("FAIL asend_reload_A got %0d want 26", a_cnt); else n_pass++;
        guard = 0;
        while (m_acnt != 5 && guard < 40) begin tick(); guard++; end
        n_checks++; if (a_cnt !== 5'd5) $display("FAIL acnt_reach5 got %0d want 5", a_cnt); else n_pass++;
        expv = 16 + int'(m_lfsr[3:0]);
        a_send = 1'b1; tick(); a_send = 1'b0;
        n_checks++; if (a_cnt !== 5'(expv) || a_cnt < 5'd16)
            $display("FAIL asend_midcount got %0d want %0d", a_cnt, expv); else n_pass++;
    endtask

    task automatic test_status_event();
        link_status_in = 32'h0000_005C;
        tick();
        n_checks++; if (link_status_event0 !== 1'b1 || link_status0 !== 32'h5C)
            $display("FAIL status_event got %b/%h want 1/0000005c", link_status_event0, link_status0); else n_pass++;
        n_checks++; if (link_status_event !== m_evt[0] || link_status !== m_ls[0])
            $display("FAIL status_event_r8 got %b/%h want %b/%h", link_status_event, link_status, m_evt[0], m_ls[0]); else n_pass++;
        tick();
        n_checks++; if (link_status_event0 !== 1'b0)
            $display("FAIL status_single_cycle got %b want 0", link_status_event0); else n_pass++;
    endtask

    task automatic test_deferred();
        next_q_det = 1'b1; tick();
        link_status_in = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (link_status_event0 !== 1'b0 || link_status0 !== 32'h5C)
                $display("FAIL qdet_blocks got %b/%h want 0/0000005c", link_status_event0, link_status0); else n_pass++;
        end
        link_status_in = 32'hCAFE_005C; next_q_det = 1'b0;
        tick();
        n_checks++; if (link_status_event0 !== 1'b0)
            $display("FAIL qdet_clear_cycle got %b want 0", link_status_event0); else n_pass++;
        tick();
        n_checks++; if (link_status_event0 !== 1'b1 || link_status0 !== 32'hCAFE_005C)
            $display("FAIL deferred_fire got %b/%h want 1/cafe005c", link_status_event0, link_status0); else n_pass++;
        n_checks++; if (link_status_event !== m_evt[0] || link_status !== m_ls[0])
            $display("FAIL deferred_r8 got %b/%h want %b/%h", link_status_event, link_status, m_evt[0], m_ls[0]); else n_pass++;
        next_state = 3'd3; tick();
        link_status_in = 32'h0000_0001; tick();
        n_checks++; if (link_status_event0 !== 1'b0) $display("FAIL sendq_blocks got %b want 0", link_status_event0); else n_pass++;
        next_state = 3'd7; tick();
        next_state = 3'd4; tick();
        n_checks++; if (link_status_event0 !== 1'b0) $display("FAIL sendrq_blocks got %b want 0", link_status_event0); else n_pass++;
        tick();
        n_checks++; if (link_status_event0 !== 1'b1 || link_status0 !== 32'h1)
            $display("FAIL state_unblock got %b/%h want 1/00000001", link_status_event0, link_status0); else n_pass++;
    endtask

    task automatic test_refresh();
        int guard, cnt8, cnt0, errs;
        guard = 0; errs = 0;
        do begin tick(); guard++; end while (link_status_event !== 1'b1 && guard < 20);
        n_checks++; if (link_status_event !== 1'b1) $display("FAIL refresh_sync got %b want 1", link_status_event); else n_pass++;
        cnt8 = 0; cnt0 = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (link_status_event === 1'b1) cnt8++;
            if (link_status_event0 === 1'b1) cnt0++;
            if (link_status_event !== ((i % 8) == 0)) errs++;
        end
        n_checks++; if (cnt8 != 4 || errs != 0) $display("FAIL refresh_period got %0d events (%0d misplaced) want 4", cnt8, errs); else n_pass++;
        n_checks++; if (cnt0 != 0) $display("FAIL refresh_disabled got %0d events want 0", cnt0); else n_pass++;
        next_q_det = 1'b1; cnt8 = 0;
        repeat (12) begin tick(); if (link_status_event === 1'b1) cnt8++; end
        next_q_det = 1'b0; tick();
        if (link_status_event === 1'b1) cnt8++;
        n_checks++; if (cnt8 != 0) $display("FAIL refresh_blocked got %0d events want 0", cnt8); else n_pass++;
        tick();
        n_checks++; if (link_status_event !== 1'b1) $display("FAIL refresh_latched got %b want 1", link_status_event); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] pool [4] = '{32'h0000_005C, 32'h0100_005C, 32'h0200_005C, 32'hFFFF_FFFF};
        logic [81:0] act, expv;
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(63) == 0);
            next_state = 3'($urandom_range(7, 1));
            next_ifg   = 1'($urandom);
            next_q_det = ($urandom_range(2) == 0);
            a_send     = ($urandom_range(7) == 0);
            if ($urandom_range(5) == 0) link_status_in = pool[$urandom_range(3)];
            tick();
            act  = {current_state, current_ifg, current_q_det, a_cnt, code_sel, link_status,
                    link_status_event, link_status0, link_status_event0};
            expv = {m_state, m_ifg, m_qdet, 5'(m_acnt), m_lfsr[0], m_ls[0], m_evt[0], m_ls[1], m_evt[1]};
            n_checks++;
            if (act !== expv) begin
                errs++;
                if (errs < 10) $display("FAIL random_cycle %0d got %h want %h", i, act, expv);
            end else n_pass++;
        end
        reset = 1'b0; a_send = 1'b0; next_q_det = 1'b0; next_state = 3'd4;
    endtask

`ifdef XAUI_TX_STATS_EN
    task automatic test_stats();
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (3) begin a_send = 1'b1; tick(); a_send = 1'b0; tick(); end
        n_checks++; if (a_count !== 16'd3 || a_count0 !== 16'd3)
            $display("FAIL stats_a_count got %0d/%0d want 3", a_count, a_count0); else n_pass++;
        next_state = 3'd3; tick(); tick();
        next_state = 3'd4; tick(); tick();
        n_checks++; if (q_count !== 16'd2 || q_count !== 16'(m_qcount))
            $display("FAIL stats_q_count got %0d want 2", q_count); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lfsr();
        test_a_send();
        test_status_event();
        test_deferred();
        test_refresh();
        test_random();
`ifdef XAUI_TX_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
